// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared types and constants for the data-memory arbiter.
//               - arb_state_t : arbiter FSM state encoding
//               - ARB_NREQ_DEFAULT / ARB_PTR_W : default requester count and
//                 matching grant-pointer width
//               - arb_ptr_w() : pointer width for any requester count
//               Optional feature macro: DMEM_ARB_RR_EN (round-robin policy).
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_RDATA = 2'd2
    } arb_state_t;

    localparam int ARB_NREQ_DEFAULT = 2;
    localparam int ARB_PTR_W        = $clog2(ARB_NREQ_DEFAULT);

    // Pointer width never collapses to zero bits, even for degenerate counts.
    function automatic int arb_ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : arb_pick
// Description : Combinational winner search. Scans the request vector
//               starting at start_i and wrapping, returning the first
//               requester found.
// Ports       : req_i    [NREQ]  request vector
//               start_i  [PTR_W] index at which the search begins
//               winner_o [PTR_W] index of the selected requester
//               found_o          at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int NREQ  = ARB_NREQ_DEFAULT,
    parameter int PTR_W = ARB_PTR_W
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] start_i,
    output logic [PTR_W-1:0] winner_o,
    output logic             found_o
);

    int pos;

    always_comb begin
        winner_o = '0;
        found_o  = 1'b0;
        pos      = 0;
        // k is the search rank; pos is the requester index holding that rank.
        for (int k = 0; k < NREQ; k++) begin
            pos = int'(start_i) + k;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            for (int j = 0; j < NREQ; j++) begin
                if (!found_o && req_i[j] && (j == pos)) begin
                    found_o  = 1'b1;
                    winner_o = PTR_W'(j);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Serialises single-access requests from NREQ requesters onto
//               a single-port synchronous data memory (1-cycle read latency).
//               Requester 0 is the CPU. Every output is registered.
//               Optional feature macro: DMEM_ARB_RR_EN
//                 defined   -> round-robin arbitration from last grant + 1
//                 undefined -> fixed priority, lowest index wins
// Ports       : clk, reset_n          clock, async active-low reset
//               req/we [NREQ]         per-requester request / write enable
//               addr/wdata            packed per-requester address / data
//               gnt/rvalid [NREQ]     one-hot grant / read-data-valid
//               rdata [WIDTH]         shared read data (qualified by rvalid)
//               busy                  arbiter not idle
//               mem_addr/we/wdata     registered memory port
//               mem_rdata             memory read data
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int D_ADDR_W = 8,
    parameter int NREQ     = ARB_NREQ_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          we,
    input  logic [NREQ*D_ADDR_W-1:0] addr,
    input  logic [NREQ*WIDTH-1:0]    wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          rvalid,
    output logic [WIDTH-1:0]         rdata,
    output logic                     busy,
    output logic [D_ADDR_W-1:0]      mem_addr,
    output logic                     mem_we,
    output logic [WIDTH-1:0]         mem_wdata,
    input  logic [WIDTH-1:0]         mem_rdata
);

    localparam int              PTR_W  = arb_ptr_w(NREQ);
    localparam logic [NREQ-1:0] ONEHOT = {{(NREQ-1){1'b0}}, 1'b1};

    arb_state_t          state_q;
    logic [NREQ-1:0]     gnt_q;
    logic [NREQ-1:0]     rvalid_q;
    logic [WIDTH-1:0]    rdata_q;
    logic                busy_q;
    logic [D_ADDR_W-1:0] mem_addr_q;
    logic                mem_we_q;
    logic [WIDTH-1:0]    mem_wdata_q;
    logic [PTR_W-1:0]    sel_q;

    logic [PTR_W-1:0]    start_d;
    logic [PTR_W-1:0]    win_d;
    logic                found_d;

`ifdef DMEM_ARB_RR_EN
    logic [PTR_W-1:0]    last_q;

    // Search begins one past the most recent grant, wrapping at NREQ.
    assign start_d = (last_q == PTR_W'(NREQ - 1)) ? '0 : last_q + 1'b1;
`else
    assign start_d = '0;
`endif

    arb_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req_i    (req),
        .start_i  (start_d),
        .winner_o (win_d),
        .found_o  (found_d)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ARB_IDLE;
            gnt_q       <= '0;
            rvalid_q    <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            sel_q       <= '0;
`ifdef DMEM_ARB_RR_EN
            last_q      <= PTR_W'(NREQ - 1);
`endif
        end else begin
            // Single-cycle strobes default low every cycle.
            gnt_q    <= '0;
            rvalid_q <= '0;
            mem_we_q <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    if (found_d) begin
                        state_q     <= ARB_ISSUE;
                        busy_q      <= 1'b1;
                        gnt_q       <= ONEHOT << win_d;
                        sel_q       <= win_d;
                        // The memory-port registers double as the access latch.
                        mem_addr_q  <= addr[win_d*D_ADDR_W +: D_ADDR_W];
                        mem_wdata_q <= wdata[win_d*WIDTH +: WIDTH];
                        mem_we_q    <= we[win_d];
`ifdef DMEM_ARB_RR_EN
                        last_q      <= win_d;
`endif
                    end
                end
                ARB_ISSUE: begin
                    // mem_we_q still holds the latched direction here.
                    if (mem_we_q) begin
                        state_q <= ARB_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= ARB_RDATA;
                    end
                end
                ARB_RDATA: begin
                    rdata_q  <= mem_rdata;
                    rvalid_q <= ONEHOT << sel_q;
                    state_q  <= ARB_IDLE;
                    busy_q   <= 1'b0;
                end
                default: begin
                    state_q <= ARB_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter. A transaction-level
//               model (occupancy countdown + pending-read queue + shadow
//               memory) predicts every output each cycle; directed checks
//               pin the model against hand-computed values.
//               Honours DMEM_ARB_RR_EN for the expected arbitration policy.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int WIDTH    = 16;
    localparam int D_ADDR_W = 8;
    localparam int NREQ     = 2;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b1;
    logic [NREQ-1:0]          req = '0;
    logic [NREQ-1:0]          we = '0;
    logic [NREQ*D_ADDR_W-1:0] addr = '0;
    logic [NREQ*WIDTH-1:0]    wdata = '0;
    logic [NREQ-1:0]          gnt;
    logic [NREQ-1:0]          rvalid;
    logic [WIDTH-1:0]         rdata;
    logic                     busy;
    logic [D_ADDR_W-1:0]      mem_addr;
    logic                     mem_we;
    logic [WIDTH-1:0]         mem_wdata;
    logic [WIDTH-1:0]         mem_rdata = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit chk_on = 1'b0;

    dmem_arbiter #(
        .WIDTH    (WIDTH),
        .D_ADDR_W (D_ADDR_W),
        .NREQ     (NREQ)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous single-port RAM seen by the DUT.
    logic [WIDTH-1:0] ram  [256];
    // Shadow copy updated by the model from predicted writes only.
    logic [WIDTH-1:0] mmem [256];

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]  = 16'hA500 ^ WIDTH'(i * 7);
            mmem[i] = 16'hA500 ^ WIDTH'(i * 7);
        end
    end

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic [NREQ-1:0]     e_gnt = '0, e_rvalid = '0;
    logic [WIDTH-1:0]    e_rdata = '0, e_mem_wdata = '0;
    logic [D_ADDR_W-1:0] e_mem_addr = '0;
    logic                e_busy = 1'b0, e_mem_we = 1'b0;
    int occ = 0;          // busy cycles remaining, counting the current one
    int rv_in = 0;        // edges until a pending read returns
    int rv_who = 0;
    logic [WIDTH-1:0] rv_data = '0;
    int m_last = NREQ - 1;

    function automatic int choose(input logic [NREQ-1:0] r);
        int s;
`ifdef DMEM_ARB_RR_EN
        s = (m_last + 1) % NREQ;
`else
        s = 0;
`endif
        for (int k = 0; k < NREQ; k++) begin
            if (r[(s + k) % NREQ]) return (s + k) % NREQ;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_gnt = '0; e_rvalid = '0; e_rdata = '0; e_busy = 1'b0;
            e_mem_addr = '0; e_mem_we = 1'b0; e_mem_wdata = '0;
            occ = 0; rv_in = 0; m_last = NREQ - 1;
        end else begin
            int w;
            e_gnt = '0; e_rvalid = '0; e_mem_we = 1'b0;
            if (rv_in > 0) begin
                rv_in--;
                if (rv_in == 0) begin
                    e_rvalid[rv_who] = 1'b1;
                    e_rdata = rv_data;
                end
            end
            if (occ > 0) begin
                occ--;
            end else if (req != '0) begin
                w = choose(req);
                m_last = w;
                e_gnt[w] = 1'b1;
                e_mem_addr  = addr[w*D_ADDR_W +: D_ADDR_W];
                e_mem_wdata = wdata[w*WIDTH +: WIDTH];
                e_mem_we    = we[w];
                if (we[w]) begin
                    mmem[e_mem_addr] = e_mem_wdata;
                    occ = 1;
                end else begin
                    rv_data = mmem[e_mem_addr];
                    rv_who  = w;
                    rv_in   = 2;
                    occ     = 2;
                end
            end
            e_busy = (occ > 0);
        end
    end

    // One compare process against the model, every cycle, on the falling edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("m_gnt",       32'(gnt),       32'(e_gnt));
            chk("m_rvalid",    32'(rvalid),    32'(e_rvalid));
            chk("m_rdata",     32'(rdata),     32'(e_rdata));
            chk("m_busy",      32'(busy),      32'(e_busy));
            chk("m_mem_we",    32'(mem_we),    32'(e_mem_we));
            chk("m_mem_addr",  32'(mem_addr),  32'(e_mem_addr));
            chk("m_mem_wdata", 32'(mem_wdata), 32'(e_mem_wdata));
        end
    end

    task automatic set_req(input int i, input logic w, input logic [D_ADDR_W-1:0] a,
                           input logic [WIDTH-1:0] d);
        we[i] = w;
        addr[i*D_ADDR_W +: D_ADDR_W] = a;
        wdata[i*WIDTH +: WIDTH] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int order [4];
        int stamp [4];
        int ng;

        // Reset.
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_gnt",   32'(gnt),      32'h0);
        chk("rst_busy",  32'(busy),     32'h0);
        chk("rst_maddr", 32'(mem_addr), 32'h0);
        chk("rst_rdata", 32'(rdata),    32'h0);
        chk_on  = 1'b1;
        reset_n = 1'b1;
        @(negedge clk);

        // CPU write 8'h10 <- 16'hBEEF.
        set_req(0, 1'b1, 8'h10, 16'hBEEF);
        req = 2'b01;
        @(negedge clk);
        chk("wr_gnt",    32'(gnt),       32'h1);
        chk("wr_we",     32'(mem_we),    32'h1);
        chk("wr_addr",   32'(mem_addr),  32'h10);
        chk("wr_wdata",  32'(mem_wdata), 32'hBEEF);
        chk("wr_busy",   32'(busy),      32'h1);
        req = 2'b00;
        @(negedge clk);
        chk("wr_idle",   32'(busy),      32'h0);
        chk("wr_we_off", 32'(mem_we),    32'h0);

        // Port 1 read of 8'h10.
        set_req(1, 1'b0, 8'h10, 16'h0);
        req = 2'b10;
        @(negedge clk);
        chk("rd_gnt", 32'(gnt), 32'h2);
        req = 2'b00;
        @(negedge clk);
        chk("rd_rv_early", 32'(rvalid), 32'h0);
        @(negedge clk);
        chk("rd_rvalid", 32'(rvalid), 32'h2);
        chk("rd_rdata",  32'(rdata),  32'hBEEF);
        @(negedge clk);
        chk("rd_rv_pulse", 32'(rvalid), 32'h0);
        chk("rd_hold",     32'(rdata),  32'hBEEF);

        // Both ports reading continuously.
        set_req(0, 1'b0, 8'h20, 16'h0);
        set_req(1, 1'b0, 8'h30, 16'h0);
        req = 2'b11;
        ng = 0;
        for (int c = 0; c < 30 && ng < 4; c++) begin
            @(negedge clk);
            if (gnt != '0) begin
                order[ng] = gnt[1] ? 1 : 0;
                stamp[ng] = cyc;
                ng++;
            end
        end
        req = 2'b00;
        chk("cont_ngrants", 32'(ng), 32'd4);
        for (int i = 0; i < ng; i++) begin
`ifdef DMEM_ARB_RR_EN
            chk("cont_order", 32'(order[i]), 32'(i % 2));
`else
            chk("cont_order", 32'(order[i]), 32'd0);
`endif
            if (i > 0) chk("cont_spacing", 32'(stamp[i] - stamp[i-1]), 32'd3);
        end
        repeat (3) @(negedge clk);

        // Port 1 arrives while port 0 read is in flight.
        set_req(0, 1'b0, 8'h40, 16'h0);
        req = 2'b01;
        @(negedge clk);
        chk("wait_g0", 32'(gnt), 32'h1);
        set_req(1, 1'b0, 8'h50, 16'h0);
        req = 2'b10;
        @(negedge clk);
        chk("wait_nog1", 32'(gnt),  32'h0);
        chk("wait_busy", 32'(busy), 32'h1);
        @(negedge clk);
        chk("wait_rv0",  32'(rvalid), 32'h1);
        chk("wait_nog2", 32'(gnt),    32'h0);
        chk("wait_idle", 32'(busy),   32'h0);
        @(negedge clk);
        chk("wait_g1", 32'(gnt), 32'h2);
        req = 2'b00;
        repeat (3) @(negedge clk);

        // Reset pulse during the read-data cycle.
        set_req(0, 1'b0, 8'h60, 16'h0);
        req = 2'b01;
        @(negedge clk);
        chk("rr_gnt", 32'(gnt), 32'h1);
        req = 2'b00;
        @(negedge clk);
        chk("rr_busy", 32'(busy), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("rr_gnt0",   32'(gnt),       32'h0);
        chk("rr_rv0",    32'(rvalid),    32'h0);
        chk("rr_rdata0", 32'(rdata),     32'h0);
        chk("rr_busy0",  32'(busy),      32'h0);
        chk("rr_addr0",  32'(mem_addr),  32'h0);
        chk("rr_wd0",    32'(mem_wdata), 32'h0);
        @(negedge clk);
        chk("rr_no_rv", 32'(rvalid), 32'h0);
        set_req(0, 1'b1, 8'h11, 16'h1111);
        set_req(1, 1'b1, 8'h22, 16'h2222);
        req = 2'b11;
        @(negedge clk);
        chk("rr_held", 32'(gnt), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rr_first", 32'(gnt), 32'h1);
        req = 2'b10;
        @(negedge clk);
        chk("rr_gap", 32'(gnt), 32'h0);
        @(negedge clk);
        chk("rr_second", 32'(gnt), 32'h2);
        req = 2'b00;
        repeat (2) @(negedge clk);

        // req dropped mid-ISSUE of a write.
        set_req(0, 1'b1, 8'h70, 16'h1234);
        req = 2'b01;
        @(negedge clk);
        chk("drop_gnt", 32'(gnt),    32'h1);
        chk("drop_we",  32'(mem_we), 32'h1);
        #1 req = 2'b00;
        #1 chk("drop_we_held", 32'(mem_we), 32'h1);
        @(negedge clk);
        chk("drop_we_end", 32'(mem_we), 32'h0);
        set_req(1, 1'b0, 8'h70, 16'h0);
        req = 2'b10;
        @(negedge clk);
        chk("drop_rd_gnt", 32'(gnt), 32'h2);
        req = 2'b00;
        repeat (2) @(negedge clk);
        chk("drop_rv",    32'(rvalid), 32'h2);
        chk("drop_rdata", 32'(rdata),  32'h1234);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the CPU's single-port data memory between NREQ requesters. Port 0 is the Control_Unit datapath (D_ADDR/D_wr). Higher ports are the debug/loader and any DMA engine. Each requester issues one read or write per req/gnt handshake. The arbiter serialises these accesses onto the memory port, which has 1-cycle synchronous read latency, and returns read data with a per-requester valid strobe.

## Interface
Parameters:
- WIDTH, 16, data word width
- D_ADDR_W, 8, data memory address width
- NREQ, 2, number of requesters (≥2); index 0 = CPU

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester access request
- we  in  NREQ  per-requester write enable (1 = write, 0 = read)
- addr  in  NREQ*D_ADDR_W  packed request addresses; slice i belongs to requester i
- wdata  in  NREQ*WIDTH  packed write data
- gnt  out  NREQ  one-hot; high for exactly the one cycle in which the access is presented to memory
- rvalid  out  NREQ  one-hot; read data valid for that requester
- rdata  out  WIDTH  shared read data, qualified by rvalid
- busy  out  1  arbiter not in IDLE
- mem_addr  out  D_ADDR_W  memory address (registered)
- mem_we  out  1  memory write strobe (registered)
- mem_wdata  out  WIDTH  memory write data (registered)
- mem_rdata  in  WIDTH  memory read data, valid one cycle after the address is presented

## Operation
- FSM states:
  - ARB_IDLE: at a rising edge where any req is high, select a winner `w`, latch we/addr/wdata of `w`, and go to ARB_ISSUE.
  - ARB_ISSUE: mem_addr/mem_wdata come from the latched values; mem_we equals the latched we; gnt[w]=1. The next state is ARB_RDATA for a read, or ARB_IDLE for a write.
  - ARB_RDATA: at the edge ending this state, rdata ← mem_rdata and rvalid[w] ← 1 for one cycle. Return to ARB_IDLE.
- Requester rule: hold req, we, addr and wdata stable until gnt[i] has been sampled high. Deassert req, or present the next request, in the cycle after gnt.
- Request changes after the arbitration edge are ignored; a latched access always completes.
- Requests arriving while busy wait. Arbitration only happens in ARB_IDLE.
- Simultaneous requests: exactly one winner, chosen by the policy in Configuration. Losers keep req high and are re-arbitrated on return to ARB_IDLE.
- mem_we is high only in ARB_ISSUE of a write.
- mem_addr and mem_wdata hold their last value between accesses.
- rdata holds its value until the next read completes.
- Reset values (asserted asynchronously, all outputs forced immediately): gnt=0, rvalid=0, rdata=0, busy=0, mem_addr=0, mem_we=0, mem_wdata=0, state=ARB_IDLE, last-grant pointer=NREQ-1 so requester 0 has first priority.
- Reset mid-access: the access is abandoned, no rvalid is issued, and a write in ARB_ISSUE is cut short (mem_we drops).

## Timing
- Write: req sampled at edge E0; gnt and mem_we high in cycle E0..E1; arbiter is IDLE after E1. Two cycles of occupancy; back-to-back writes every 2 cycles.
- Read: gnt in cycle E0..E1; rvalid and rdata valid in cycle E2..E3. Three cycles of occupancy.
- rvalid never coincides with gnt to the same requester.
- No combinational path from req to any output; all outputs are registered.

## Configuration
- DMEM_ARB_RR_EN defined:
  - Round-robin: search starts at (last_grant+1) mod NREQ and wraps.
  - last_grant updates on every grant.
  - With all requesters continuously requesting, each is granted once per NREQ grants.
- Undefined: fixed priority, lowest index wins; the pointer is unused and optimised out.
- The CPU always wins; the debug port starves while the CPU is streaming.

## Structure
- Package dmem_arb_pkg:
  - state enum arb_state_t {ARB_IDLE, ARB_ISSUE, ARB_RDATA}
  - localparam for the pointer width, $clog2(NREQ)
- Sub-module arb_pick: purely combinational. Inputs are the request vector and the start index; outputs are a winner index and a found flag.
  - Under DMEM_ARB_RR_EN the top level drives start = last_grant+1.
  - Otherwise start = 0.
- The top level holds the FSM, the latch registers and the pointer.

## Test plan
- Reset release, then CPU write: req[0]=1, we=1, addr=8'h10, wdata=16'hBEEF → next cycle gnt=2'b01, mem_we=1, mem_addr=8'h10, mem_wdata=16'hBEEF; busy low one cycle later.
- Port 1 read of 8'h10 with the model returning 16'hBEEF → gnt=2'b10, then two cycles later rvalid=2'b10, rdata=16'hBEEF.
- Both requesting reads continuously with DMEM_ARB_RR_EN → grant order 0,1,0,1 at a 3-cycle spacing. Without the macro → port 0 only, port 1 never granted.
- req[1] raised while busy with a port-0 read → no gnt[1] until IDLE; then gnt=2'b10 the cycle after IDLE.
- reset_n pulsed low during ARB_RDATA → all outputs 0 immediately, no rvalid; first post-reset grant goes to port 0.
- req[0] dropped during ARB_ISSUE of a write → write still completes (mem_we=1 for that cycle).
